// File: rtl/uart_tx_buffered.sv
// UART transmitter with a FIFO front end. Queued words are sent back-to-back
// as start / data (LSB first) / optional parity / stop bits on a registered line.
module uart_tx_buffered #(
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [WORD_WIDTH-1:0]         tx_data_in,
  input  logic                          tx_data_valid,
  output logic                          tx_ready,
  output logic                          tx_data_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          s_idle,
  output logic                          s_start,
  output logic                          s_data,
  output logic                          s_parity,
  output logic                          s_stop
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_WIDTH - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic          PAR_INIT   = 1'(PARITY_ODD);

  // One-hot encoding so the debug flags come straight off the state flops.
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_START  = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_PARITY = 5'b01000;
  localparam logic [4:0] S_STOP   = 5'b10000;

  logic [4:0]            state;
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  parity_bit;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  push;
  logic                  pop;
  logic                  baud_tick;

  assign tx_ready  = (fifo_count != FULL_COUNT);
  assign push      = tx_data_valid && tx_ready;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);
  assign baud_tick = (baud_cnt == BAUD_LAST);

  assign s_idle   = state[0];
  assign s_start  = state[1];
  assign s_data   = state[2];
  assign s_parity = state[3];
  assign s_stop   = state[4];
  assign tx_busy  = !s_idle || (fifo_count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= tx_data_in;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tx_data_out <= 1'b1;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        baud_cnt <= baud_tick ? '0 : baud_cnt + CW'(1);
      end
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg       <= mem[rd_ptr];
            parity_bit  <= (^mem[rd_ptr]) ^ PAR_INIT;
            tx_data_out <= 1'b0;
            state       <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx_data_out <= shreg[0];
            bit_cnt     <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_data_out <= parity_bit;
                state       <= S_PARITY;
              end else begin
                tx_data_out <= 1'b1;
                stop_cnt    <= 1'b0;
                state       <= S_STOP;
              end
            end else begin
              bit_cnt     <= bit_cnt + BW'(1);
              shreg       <= shreg >> 1;
              tx_data_out <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx_data_out <= 1'b1;
            stop_cnt    <= 1'b0;
            state       <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx_data_out <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three configurations (8N1, 8E1, 8O2) share one
// stimulus stream and are compared cycle by cycle against a frame-level model.
module tb_uart_tx_buffered;

  localparam int CPB   = 5;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] din;

  logic       line [3];
  logic       rdy  [3];
  logic       busy [3];
  logic       f_id [3];
  logic       f_st [3];
  logic       f_da [3];
  logic       f_pa [3];
  logic       f_sp [3];
  logic [4:0] cnt  [3];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_RATE(500), .BAUD_RATE(100), .WORD_WIDTH(8), .FIFO_DEPTH(DEPTH),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clock(clk), .rst_n(rst_n), .tx_data_in(din), .tx_data_valid(valid),
    .tx_ready(rdy[0]), .tx_data_out(line[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]),
    .s_idle(f_id[0]), .s_start(f_st[0]), .s_data(f_da[0]), .s_parity(f_pa[0]), .s_stop(f_sp[0]));

  uart_tx_buffered #(.CLK_RATE(500), .BAUD_RATE(100), .WORD_WIDTH(8), .FIFO_DEPTH(DEPTH),
                     .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clock(clk), .rst_n(rst_n), .tx_data_in(din), .tx_data_valid(valid),
    .tx_ready(rdy[1]), .tx_data_out(line[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]),
    .s_idle(f_id[1]), .s_start(f_st[1]), .s_data(f_da[1]), .s_parity(f_pa[1]), .s_stop(f_sp[1]));

  uart_tx_buffered #(.CLK_RATE(500), .BAUD_RATE(100), .WORD_WIDTH(8), .FIFO_DEPTH(DEPTH),
                     .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clock(clk), .rst_n(rst_n), .tx_data_in(din), .tx_data_valid(valid),
    .tx_ready(rdy[2]), .tx_data_out(line[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]),
    .s_idle(f_id[2]), .s_start(f_st[2]), .s_data(f_da[2]), .s_parity(f_pa[2]), .s_stop(f_sp[2]));

  // Frame length in bits and parity settings of each configuration.
  int nbits [3] = '{10, 11, 12};
  int pen   [3] = '{0, 1, 1};
  int podd  [3] = '{0, 0, 1};

  logic [7:0] mq [3][DEPTH];
  int         mrd [3];
  int         mwr [3];
  int         mc  [3];
  int         nfree [3];
  int         lpop  [3];
  logic [7:0] cur [3];

  int t = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", tag, i, t, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mrd[i] = 0; mwr[i] = 0; mc[i] = 0; nfree[i] = 0; lpop[i] = -100000; cur[i] = '0;
  endtask

  function automatic logic exp_bit(input int i, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[i][k-1];
    if (k == 9 && pen[i] != 0) return (^cur[i]) ^ podd[i][0];
    return 1'b1;
  endfunction

  function automatic logic [4:0] exp_flags(input int i, input int k);
    if (k == 0) return 5'b01000;
    if (k <= 8) return 5'b00100;
    if (k == 9 && pen[i] != 0) return 5'b00010;
    return 5'b00001;
  endfunction

  task automatic check_all();
    bit in_frame;
    int k;
    for (int i = 0; i < 3; i++) begin
      in_frame = (t >= lpop[i]) && (t < lpop[i] + nbits[i] * CPB);
      k = in_frame ? (t - lpop[i]) / CPB : 0;
      check("line", i, 32'(line[i]), in_frame ? 32'(exp_bit(i, k)) : 32'd1);
      check("flags", i, 32'({f_id[i], f_st[i], f_da[i], f_pa[i], f_sp[i]}),
            in_frame ? 32'(exp_flags(i, k)) : 32'b10000);
      check("count", i, 32'(cnt[i]), 32'(mc[i]));
      check("ready", i, 32'(rdy[i]), 32'(mc[i] < DEPTH));
      check("busy", i, 32'(busy[i]), 32'((mc[i] > 0) || in_frame));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bit pop, push;
    valid = v;
    din   = d;
    @(posedge clk);
    t++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else begin
        pop  = (t >= nfree[i]) && (mc[i] > 0);
        push = v && (mc[i] < DEPTH);
        if (pop) begin
          cur[i]   = mq[i][mrd[i]];
          mrd[i]   = (mrd[i] + 1) % DEPTH;
          lpop[i]  = t;
          nfree[i] = t + nbits[i] * CPB + 1;
        end
        if (push) begin
          mq[i][mwr[i]] = d;
          mwr[i] = (mwr[i] + 1) % DEPTH;
        end
        mc[i] = mc[i] + int'(push) - int'(pop);
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    din   = '0;
    for (int i = 0; i < 3; i++) model_reset(i);

    // Reset state, then release between clock edges.
    idle_steps(3);
    rst_n = 1'b1;
    idle_steps(2);

    // Single word into an empty FIFO: line low one clock after the push.
    step(1'b1, 8'h5B);
    idle_steps(70);

    // Burst past full, then hold 0xAA while full so only freed slots accept it.
    for (int j = 0; j < 18; j++) step(1'b1, 8'(j));
    for (int j = 0; j < 200; j++) step(1'b1, 8'hAA);
    idle_steps(1100);

    // Push into empty idle FIFO (no pop), then push alongside a pop at count 1.
    step(1'b1, 8'h78);
    step(1'b1, 8'h3C);
    idle_steps(140);

    // Randomized traffic.
    for (int j = 0; j < 600; j++) step(($urandom_range(0, 2) == 0), 8'($urandom));
    idle_steps(1100);

    // Async reset in the middle of the data bits of 0x91.
    step(1'b1, 8'h91);
    idle_steps(4 * CPB);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    check_all();
    idle_steps(2);
    rst_n = 1'b1;
    idle_steps(1);
    step(1'b1, 8'h78);
    idle_steps(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
